// File: rtl/mux_4to1.sv
// mux_4to1: 4-lane selector with a combinational output and a one-cycle registered copy.
module mux_4to1 #(
  parameter int DATA_W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DATA_W-1:0] a,
  input  logic [1:0]          sel,
  input  logic                in_valid,
  output logic [DATA_W-1:0]   y,
  output logic [DATA_W-1:0]   y_q,
  output logic [1:0]          sel_q,
  output logic                out_valid
);
  logic [DATA_W-1:0] y_d;
  logic [1:0]        sel_d;
  logic              valid_d;
  // An unknown select poisons the whole output rather than merging lanes bitwise.
  always_comb begin
    case (sel)
      2'd0:    y = a[0*DATA_W +: DATA_W];
      2'd1:    y = a[1*DATA_W +: DATA_W];
      2'd2:    y = a[2*DATA_W +: DATA_W];
      2'd3:    y = a[3*DATA_W +: DATA_W];
      default: y = {DATA_W{1'bx}};
    endcase
  end
  assign y_d     = rst ? '0 : in_valid ? y : y_q;
  assign sel_d   = rst ? 2'b00 : in_valid ? sel : sel_q;
  assign valid_d = !rst && in_valid;
  always_ff @(posedge clk) begin
    y_q       <= y_d;
    sel_q     <= sel_d;
    out_valid <= valid_d;
  end
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: checks DATA_W=1 and DATA_W=8 instances with a sweep, a vector table and a random run.
module tb_mux_4to1;
  logic        clk = 1'b0;
  logic        rst, iv;
  logic [1:0]  sel;
  logic [3:0]  a1;
  logic [31:0] a8;
  logic        y1, yq1, ov1, ov8;
  logic [7:0]  y8, yq8;
  logic [1:0]  sq1, sq8;
  int pass_cnt = 0;
  int tot_cnt  = 0;

  mux_4to1 #(.DATA_W(1)) d1 (
    .clk(clk), .rst(rst), .a(a1), .sel(sel), .in_valid(iv),
    .y(y1), .y_q(yq1), .sel_q(sq1), .out_valid(ov1)
  );
  mux_4to1 #(.DATA_W(8)) d8 (
    .clk(clk), .rst(rst), .a(a8), .sel(sel), .in_valid(iv),
    .y(y8), .y_q(yq8), .sel_q(sq8), .out_valid(ov8)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic       r, v;
    logic [3:0] a;
    logic [1:0] s;
    logic       ey, eyq;
    logic [1:0] esq;
    logic       eov;
    logic [7:0] ey8, eyq8;
  } vec_t;
  vec_t tv[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference selection: shift the packed bus down by sel lanes and mask one lane.
  function automatic logic [7:0] lane(input logic [31:0] a, input int w, input logic [1:0] s);
    logic [31:0] t;
    t = (a >> (int'(s) * w)) & ((32'd1 << w) - 32'd1);
    return t[7:0];
  endfunction

  logic       m_yq1, m_ov;
  logic [7:0] m_yq8;
  logic [1:0] m_sq;

  initial begin
    rst = 1'b0; iv = 1'b0; sel = 2'd0; a1 = 4'd0; a8 = 32'hDDCCBBAA;
    for (int av = 0; av < 16; av++)
      for (int sv = 0; sv < 4; sv++) begin
        a1 = 4'(av); sel = 2'(sv);
        #10;
        chk($sformatf("sweep a=%0d sel=%0d", av, sv), {31'd0, y1}, {31'd0, a1[sel]});
      end

    tv[0]  = '{1'b1, 1'b1, 4'hF, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 8'hAA, 8'h00};
    tv[1]  = '{1'b1, 1'b1, 4'hF, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 8'hAA, 8'h00};
    tv[2]  = '{1'b0, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 8'hBB, 8'hBB};
    tv[3]  = '{1'b0, 1'b0, 4'h2, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0, 8'hBB, 8'hBB};
    tv[4]  = '{1'b0, 1'b0, 4'h0, 2'd2, 1'b0, 1'b1, 2'd1, 1'b0, 8'hCC, 8'hBB};
    tv[5]  = '{1'b0, 1'b1, 4'hA, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 8'hAA, 8'hAA};
    tv[6]  = '{1'b0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 8'hBB, 8'hBB};
    tv[7]  = '{1'b0, 1'b1, 4'hA, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 8'hCC, 8'hCC};
    tv[8]  = '{1'b0, 1'b1, 4'hA, 2'd3, 1'b1, 1'b1, 2'd3, 1'b1, 8'hDD, 8'hDD};
    tv[9]  = '{1'b1, 1'b1, 4'hA, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 8'hDD, 8'h00};
    tv[10] = '{1'b0, 1'b1, 4'hA, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 8'hBB, 8'hBB};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = tv[i].r; iv = tv[i].v; a1 = tv[i].a; sel = tv[i].s; a8 = 32'hDDCCBBAA;
      #10;
      chk($sformatf("tv%0d y", i),  {31'd0, y1}, {31'd0, tv[i].ey});
      chk($sformatf("tv%0d y8", i), {24'd0, y8}, {24'd0, tv[i].ey8});
      @(posedge clk); #1;
      chk($sformatf("tv%0d y_q", i),     {31'd0, yq1}, {31'd0, tv[i].eyq});
      chk($sformatf("tv%0d sel_q", i),   {30'd0, sq1}, {30'd0, tv[i].esq});
      chk($sformatf("tv%0d valid", i),   {31'd0, ov1}, {31'd0, tv[i].eov});
      chk($sformatf("tv%0d y_q8", i),    {24'd0, yq8}, {24'd0, tv[i].eyq8});
      chk($sformatf("tv%0d sel_q8", i),  {30'd0, sq8}, {30'd0, tv[i].esq});
      chk($sformatf("tv%0d valid8", i),  {31'd0, ov8}, {31'd0, tv[i].eov});
    end

    m_yq1 = tv[10].eyq; m_yq8 = tv[10].eyq8; m_sq = tv[10].esq; m_ov = tv[10].eov;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst = ($urandom_range(15) == 0);
      iv  = 1'($urandom);
      a1  = 4'($urandom);
      a8  = $urandom;
      sel = 2'($urandom);
      #10;
      chk($sformatf("rnd%0d y", i),  {31'd0, y1}, {24'd0, lane({28'd0, a1}, 1, sel)});
      chk($sformatf("rnd%0d y8", i), {24'd0, y8}, {24'd0, lane(a8, 8, sel)});
      if (rst) begin
        m_yq1 = 1'b0; m_yq8 = 8'd0; m_sq = 2'd0; m_ov = 1'b0;
      end else if (iv) begin
        m_yq1 = lane({28'd0, a1}, 1, sel) != 8'd0; m_yq8 = lane(a8, 8, sel); m_sq = sel; m_ov = 1'b1;
      end else m_ov = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("rnd%0d y_q", i),   {31'd0, yq1}, {31'd0, m_yq1});
      chk($sformatf("rnd%0d y_q8", i),  {24'd0, yq8}, {24'd0, m_yq8});
      chk($sformatf("rnd%0d sel_q", i), {28'd0, sq1, sq8}, {28'd0, m_sq, m_sq});
      chk($sformatf("rnd%0d valid", i), {30'd0, ov1, ov8}, {30'd0, m_ov, m_ov});
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- 4-to-1 selector: picks one of four equal-width lanes packed into input bus `a`, using 2-bit `sel`.
- Provides a combinational output `y` for purely combinational use.
- Also provides a one-cycle registered copy (`y_q`, `sel_q`, `out_valid`) for use in pipelined datapaths.
- Used as a leaf primitive in combinational-circuit blocks and as a retimed selector stage in clocked paths.

Parameters:
- DATA_W, 1, width in bits of each lane and of the output; must be >= 1.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  synchronous, active-high reset.
- a  input  4*DATA_W  packed lanes: lane k occupies bits [k*DATA_W +: DATA_W], k = 0..3.
- sel  input  2  lane select, binary encoded.
- in_valid  input  1  qualifies `a`/`sel` for the registered path.
- y  output  DATA_W  combinational selected lane.
- y_q  output  DATA_W  registered selected lane.
- sel_q  output  2  registered select that produced `y_q`.
- out_valid  output  1  registered `in_valid`; qualifies `y_q` and `sel_q`.

Behaviour:
- Combinational path:
  - y = lane[sel] at all times, independent of clk, rst and in_valid.
  - With DATA_W=1: y = a[sel], i.e. sel=0 gives a[0], 1 gives a[1], 2 gives a[2], 3 gives a[3].
  - No latches. Every sel value is decoded explicitly.
  - If any bit of sel is X/Z, y is driven to all-X in simulation; synthesis treats this as don't-care.
  - y settles within the same delta/time step as an input change. A bench sampling 10 time units after stimulus sees the settled value.
- Registered path (all updates on rising clk only):
  - rst=1 at an edge: y_q <= 0, sel_q <= 2'b00, out_valid <= 0. Reset overrides in_valid.
  - rst=0 and in_valid=1: y_q <= lane[sel], sel_q <= sel, out_valid <= 1.
  - rst=0 and in_valid=0: y_q and sel_q hold their previous values; out_valid <= 0.
  - Latency is exactly 1 cycle from an accepted input to out_valid=1.
  - Throughput is one selection per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
  - Reset asserted mid-stream drops the in-flight result. out_valid is 0 on the cycle following the reset edge.
- Power-up: register contents are undefined until the first reset edge. Combinational y is valid immediately.
- Width rules:
  - No arithmetic is performed. Lanes are passed through bit-exact, with no sign extension or truncation.
  - sel has exactly 4 codes, so there is no out-of-range case.
- Lane indexing is little-endian: lane 0 is in the least-significant bits of `a`.

Test Plan:
- Exhaustive combinational sweep, DATA_W=1: for a = 0..15 and sel = 0..3 (64 vectors, 10 time units apart), y == a[sel]. Examples:
  - a=4'b0100, sel=2 -> y=1.
  - a=4'b0100, sel=1 -> y=0.
  - a=4'b1000, sel=3 -> y=1.
  - a=4'b0111, sel=3 -> y=0.
- Reset:
  - Hold rst=1 for 2 edges with in_valid=1, a=4'b1111 -> y_q=0, sel_q=0, out_valid=0.
  - Throughout, y tracks a[sel] (y=1).
- Pipeline latency:
  - Drive in_valid=1, a=4'b0010, sel=1 for one edge, then in_valid=0.
  - Next cycle: out_valid=1, y_q=1, sel_q=1.
  - Following cycle: out_valid=0 and y_q holds 1.
- Back-to-back: drive sel=0,1,2,3 on consecutive edges with a=4'b1010 and in_valid=1 -> y_q sequence 0,1,0,1, each one cycle late, with out_valid continuously 1.
- Reset mid-stream: with in_valid=1 streaming, assert rst for one edge -> next cycle out_valid=0 and y_q=0. Streaming resumes on the following edge with correct data.
- Wide lanes, DATA_W=8: a = {8'hDD, 8'hCC, 8'hBB, 8'hAA} -> y = 8'hAA, 8'hBB, 8'hCC, 8'hDD for sel = 0..3. The registered y_q matches one cycle later.
